// File: rtl/res_pair_checker_pkg.sv
// res_chk_pkg: shared types and default parameter values for the result-pair checker.
//   chk_state_e : run sequencer states (IDLE, RUN, DONE)
//   DEF_*       : default parameter values used by the interface, buffer and top level
package res_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int DEF_DATA_WIDTH     = 256;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/res_pair_checker_if.sv
// res_pair_checker_if: control, stream and status signals of the result-pair checker.
//   master : the side that drives start/expected_count and both result streams, and reads status
//   slave  : the checker itself
//   Streams : res_valid_0/res_data_0, res_valid_1/res_data_1 (capture on valid rising edge)
//   Status  : busy, done, pass, pass_cnt, fail_cnt, mismatch_*, ovf_0, ovf_1, timeout, leftover
interface res_pair_checker_if
  import res_chk_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

  logic                  start;
  logic [CNT_WIDTH-1:0]  expected_count;
  logic                  res_valid_0;
  logic [DATA_WIDTH-1:0] res_data_0;
  logic                  res_valid_1;
  logic [DATA_WIDTH-1:0] res_data_1;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_WIDTH-1:0]  pass_cnt;
  logic [CNT_WIDTH-1:0]  fail_cnt;
  logic                  mismatch_valid;
  logic [CNT_WIDTH-1:0]  mismatch_idx;
  logic [DATA_WIDTH-1:0] mismatch_data_0;
  logic [DATA_WIDTH-1:0] mismatch_data_1;
  logic                  ovf_0;
  logic                  ovf_1;
  logic                  timeout;
  logic                  leftover;

  modport master (
    output start, expected_count, res_valid_0, res_data_0, res_valid_1, res_data_1,
    input  busy, done, pass, pass_cnt, fail_cnt, mismatch_valid, mismatch_idx,
           mismatch_data_0, mismatch_data_1, ovf_0, ovf_1, timeout, leftover
  );

  modport slave (
    input  start, expected_count, res_valid_0, res_data_0, res_valid_1, res_data_1,
    output busy, done, pass, pass_cnt, fail_cnt, mismatch_valid, mismatch_idx,
           mismatch_data_0, mismatch_data_1, ovf_0, ovf_1, timeout, leftover
  );

endinterface

// File: rtl/res_pair_checker_fifo.sv
// res_chk_fifo: synchronous FIFO holding one result stream.
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous flush (start of a run)
//   push, din    : write request and data; accepted when not full, or when full with a pop
//   pop, dout    : read request (ignored when empty) and head-of-queue data
//   full, empty  : occupancy flags
module res_chk_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s  = pop & ~empty;
  // A pop frees the head slot in the same edge, so a push into a full buffer can still land.
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update with synchronous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Storage array write; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clr) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/res_pair_checker.sv
// res_pair_checker: in-order checker comparing a DUT result stream against a golden stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : res_pair_checker_if.slave carrying start/expected_count, both streams and
//              the run status (busy, done, pass, counters, first mismatch, ovf, timeout, leftover)
// Each stream is captured on the rising edge of its valid while running, buffered, and popped
// in pairs; a registered compare stage updates the counters one cycle after each pop.
module res_pair_checker
  import res_chk_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               rst,
  res_pair_checker_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) return v;
    else return v + 1'b1;
  endfunction

  chk_state_e            state_r, state_n;
  logic                  valid_0_d1_r, valid_1_d1_r;
  logic                  push_0_s, push_1_s, pop_s, start_acc_s, wd_hit_s, timeout_hit_s;
  logic                  full_0_s, full_1_s, empty_0_s, empty_1_s;
  logic [DATA_WIDTH-1:0] head_0_s, head_1_s;
  logic [CNT_WIDTH-1:0]  expected_r, issued_r, compared_r, cmp_idx_r;
  logic                  cmp_valid_r, cmp_eq_r;
  logic [DATA_WIDTH-1:0] cmp_d0_r, cmp_d1_r;
  logic [CNT_WIDTH-1:0]  pass_cnt_r, fail_cnt_r, mismatch_idx_r;
  logic                  mismatch_valid_r;
  logic [DATA_WIDTH-1:0] mismatch_d0_r, mismatch_d1_r;
  logic                  ovf_0_r, ovf_1_r, timeout_r, leftover_r, done_first_r;
  logic [WD_W-1:0]       wd_r;

  assign push_0_s    = bus.res_valid_0 & ~valid_0_d1_r & (state_r == RUN);
  assign push_1_s    = bus.res_valid_1 & ~valid_1_d1_r & (state_r == RUN);
  assign pop_s       = (state_r == RUN) & ~empty_0_s & ~empty_1_s & (issued_r < expected_r);
  assign start_acc_s = bus.start & (state_r != RUN);
  assign wd_hit_s    = (wd_r == WD_LIMIT);

  res_chk_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_0 (
    .clk(clk), .rst(rst), .clr(start_acc_s), .push(push_0_s), .pop(pop_s),
    .din(bus.res_data_0), .dout(head_0_s), .full(full_0_s), .empty(empty_0_s)
  );

  res_chk_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk(clk), .rst(rst), .clr(start_acc_s), .push(push_1_s), .pop(pop_s),
    .din(bus.res_data_1), .dout(head_1_s), .full(full_1_s), .empty(empty_1_s)
  );

  // Valid delay registers for edge detection; they track the inputs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_0_d1_r <= 1'b0;
      valid_1_d1_r <= 1'b0;
    end else begin
      valid_0_d1_r <= bus.res_valid_0;
      valid_1_d1_r <= bus.res_valid_1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n;
  end

  // Sequencer next state. compared==expected implies the compare stage is empty, so completion
  // is checked first and wins over a simultaneous watchdog expiry.
  always_comb begin
    state_n       = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_acc_s) state_n = RUN;
        else             state_n = IDLE;
      end
      RUN: begin
        if (compared_r == expected_r) begin
          state_n = DONE;
        end else if (wd_hit_s && !cmp_valid_r) begin
          state_n       = DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (start_acc_s) state_n = RUN;
        else             state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pop/issue stage: latches the popped pair and its index for the compare stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_r  <= '0;
      issued_r    <= '0;
      cmp_valid_r <= 1'b0;
      cmp_eq_r    <= 1'b0;
      cmp_idx_r   <= '0;
      cmp_d0_r    <= '0;
      cmp_d1_r    <= '0;
    end else if (start_acc_s) begin
      expected_r  <= bus.expected_count;
      issued_r    <= '0;
      cmp_valid_r <= 1'b0;
    end else begin
      cmp_valid_r <= pop_s;
      if (pop_s) begin
        issued_r  <= issued_r + 1'b1;
        cmp_eq_r  <= (head_0_s == head_1_s);
        cmp_idx_r <= issued_r;
        cmp_d0_r  <= head_0_s;
        cmp_d1_r  <= head_1_s;
      end
    end
  end

  // Compare stage retirement: counters and first-mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compared_r       <= '0;
      pass_cnt_r       <= '0;
      fail_cnt_r       <= '0;
      mismatch_valid_r <= 1'b0;
      mismatch_idx_r   <= '0;
      mismatch_d0_r    <= '0;
      mismatch_d1_r    <= '0;
    end else if (start_acc_s) begin
      compared_r       <= '0;
      pass_cnt_r       <= '0;
      fail_cnt_r       <= '0;
      mismatch_valid_r <= 1'b0;
      mismatch_idx_r   <= '0;
      mismatch_d0_r    <= '0;
      mismatch_d1_r    <= '0;
    end else if (cmp_valid_r) begin
      compared_r <= compared_r + 1'b1;
      if (cmp_eq_r) begin
        pass_cnt_r <= sat_inc(pass_cnt_r);
      end else begin
        fail_cnt_r <= sat_inc(fail_cnt_r);
        if (!mismatch_valid_r) begin
          mismatch_valid_r <= 1'b1;
          mismatch_idx_r   <= cmp_idx_r;
          mismatch_d0_r    <= cmp_d0_r;
          mismatch_d1_r    <= cmp_d1_r;
        end
      end
    end
  end

  // Sticky flags, watchdog and the leftover sample taken after the first DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_0_r      <= 1'b0;
      ovf_1_r      <= 1'b0;
      timeout_r    <= 1'b0;
      leftover_r   <= 1'b0;
      done_first_r <= 1'b0;
      wd_r         <= '0;
    end else if (start_acc_s) begin
      ovf_0_r      <= 1'b0;
      ovf_1_r      <= 1'b0;
      timeout_r    <= 1'b0;
      leftover_r   <= 1'b0;
      done_first_r <= 1'b0;
      wd_r         <= '0;
    end else begin
      if (push_0_s && full_0_s && !pop_s) ovf_0_r <= 1'b1;
      if (push_1_s && full_1_s && !pop_s) ovf_1_r <= 1'b1;
      if (timeout_hit_s) timeout_r <= 1'b1;
      done_first_r <= (state_r == RUN) && (state_n == DONE);
      if (done_first_r) leftover_r <= ~empty_0_s | ~empty_1_s;
      if (state_r == RUN) begin
        if (push_0_s || push_1_s || pop_s) wd_r <= '0;
        else if (!wd_hit_s)                wd_r <= wd_r + 1'b1;
      end
    end
  end

  assign bus.busy            = (state_r == RUN);
  assign bus.done            = (state_r == DONE);
  // Buffers are frozen in DONE, so the empty flags give the leftover verdict from the first
  // DONE cycle, before leftover_r itself is sampled.
  assign bus.pass            = (state_r == DONE) && (fail_cnt_r == '0) && !timeout_r &&
                               !ovf_0_r && !ovf_1_r && !leftover_r && empty_0_s && empty_1_s;
  assign bus.pass_cnt        = pass_cnt_r;
  assign bus.fail_cnt        = fail_cnt_r;
  assign bus.mismatch_valid  = mismatch_valid_r;
  assign bus.mismatch_idx    = mismatch_idx_r;
  assign bus.mismatch_data_0 = mismatch_d0_r;
  assign bus.mismatch_data_1 = mismatch_d1_r;
  assign bus.ovf_0           = ovf_0_r;
  assign bus.ovf_1           = ovf_1_r;
  assign bus.timeout         = timeout_r;
  assign bus.leftover        = leftover_r;

endmodule

// File: tb/tb_res_pair_checker.sv
// Directed bench for res_pair_checker: one task per scenario, inline comparisons.
module tb_res_pair_checker;

  localparam int DW = 256;
  localparam int CW = 16;
  localparam int FD = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  res_pair_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  res_pair_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic start_run(input logic [CW-1:0] n);
    bus.expected_count = n;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic pulse_both(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.res_data_0 = d0; bus.res_data_1 = d1;
    bus.res_valid_0 = 1'b1; bus.res_valid_1 = 1'b1;
    cyc();
    bus.res_valid_0 = 1'b0; bus.res_valid_1 = 1'b0;
    cyc();
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (bus.done === 1'b1) ok = 1'b1;
      else cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    total++; if ({bus.busy, bus.done, bus.pass, bus.mismatch_valid, bus.ovf_0, bus.ovf_1, bus.timeout, bus.leftover} !== 8'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=%b", {bus.busy, bus.done, bus.pass, bus.mismatch_valid, bus.ovf_0, bus.ovf_1, bus.timeout, bus.leftover}, 8'b0); end
    total++; if ({bus.pass_cnt, bus.fail_cnt, bus.mismatch_idx} !== 48'd0) begin
      bad++; $display("FAIL reset_counters got=%h exp=0", {bus.pass_cnt, bus.fail_cnt, bus.mismatch_idx}); end
    total++; if ((bus.mismatch_data_0 | bus.mismatch_data_1) !== 256'd0) begin
      bad++; $display("FAIL reset_mismatch_data got=%h exp=0", bus.mismatch_data_0 | bus.mismatch_data_1); end
    rst = 1'b0;
    cyc();
    total++; if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL reset_idle got=%b exp=00", {bus.busy, bus.done}); end
    pulse_both(256'h5, 256'h5);
    pulse_both(256'h6, 256'h7);
    cycles(2);
    total++; if ({bus.pass_cnt, bus.fail_cnt, bus.busy, bus.done} !== 34'd0) begin
      bad++; $display("FAIL idle_edges_ignored got=%h exp=0", {bus.pass_cnt, bus.fail_cnt, bus.busy, bus.done}); end
  endtask

  task automatic test_lagged_pass();
    bit ok;
    start_run(16'd4);
    for (int c = 0; c < 12; c++) begin
      bus.res_valid_0 = 1'b0; bus.res_valid_1 = 1'b0;
      if (c < 8 && c % 2 == 0) begin bus.res_valid_0 = 1'b1; bus.res_data_0 = 256'(32'hA + c / 2); end
      if (c >= 3 && c < 11 && (c - 3) % 2 == 0) begin bus.res_valid_1 = 1'b1; bus.res_data_1 = 256'(32'hA + (c - 3) / 2); end
      cyc();
    end
    bus.res_valid_0 = 1'b0; bus.res_valid_1 = 1'b0;
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL lag_done got=0 exp=1"); end
    cyc();
    total++; if (bus.pass !== 1'b1) begin bad++; $display("FAIL lag_pass got=%b exp=1", bus.pass); end
    total++; if (bus.pass_cnt !== 16'd4) begin bad++; $display("FAIL lag_pass_cnt got=%0d exp=4", bus.pass_cnt); end
    total++; if (bus.fail_cnt !== 16'd0) begin bad++; $display("FAIL lag_fail_cnt got=%0d exp=0", bus.fail_cnt); end
    total++; if ({bus.leftover, bus.timeout, bus.mismatch_valid} !== 3'b000) begin
      bad++; $display("FAIL lag_flags got=%b exp=000", {bus.leftover, bus.timeout, bus.mismatch_valid}); end
  endtask

  task automatic test_mismatch();
    bit ok;
    start_run(16'd3);
    pulse_both(256'd1, 256'd1);
    pulse_both(256'd2, 256'd9);
    pulse_both(256'd3, 256'd3);
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL mm_done got=0 exp=1"); end
    cyc();
    total++; if (bus.fail_cnt !== 16'd1) begin bad++; $display("FAIL mm_fail_cnt got=%0d exp=1", bus.fail_cnt); end
    total++; if (bus.pass_cnt !== 16'd2) begin bad++; $display("FAIL mm_pass_cnt got=%0d exp=2", bus.pass_cnt); end
    total++; if ({bus.mismatch_valid, bus.mismatch_idx} !== {1'b1, 16'd1}) begin
      bad++; $display("FAIL mm_idx got=%b/%0d exp=1/1", bus.mismatch_valid, bus.mismatch_idx); end
    total++; if (bus.mismatch_data_0 !== 256'd2 || bus.mismatch_data_1 !== 256'd9) begin
      bad++; $display("FAIL mm_data got=%0d/%0d exp=2/9", bus.mismatch_data_0, bus.mismatch_data_1); end
    total++; if (bus.pass !== 1'b0) begin bad++; $display("FAIL mm_pass got=%b exp=0", bus.pass); end
  endtask

  task automatic test_zero_count();
    start_run(16'd0);
    total++; if ({bus.busy, bus.done} !== 2'b10) begin
      bad++; $display("FAIL zero_run_cycle got=%b exp=10", {bus.busy, bus.done}); end
    total++; if ({bus.pass_cnt, bus.fail_cnt, bus.mismatch_idx, bus.mismatch_valid} !== 49'd0) begin
      bad++; $display("FAIL zero_clear got=%h exp=0", {bus.pass_cnt, bus.fail_cnt, bus.mismatch_idx, bus.mismatch_valid}); end
    total++; if (bus.mismatch_data_1 !== 256'd0) begin
      bad++; $display("FAIL zero_clear_data got=%0d exp=0", bus.mismatch_data_1); end
    cyc();
    total++; if ({bus.busy, bus.done, bus.pass} !== 3'b011) begin
      bad++; $display("FAIL zero_done got=%b exp=011", {bus.busy, bus.done, bus.pass}); end
    cyc();
    total++; if ({bus.pass, bus.leftover} !== 2'b10) begin
      bad++; $display("FAIL zero_pass_hold got=%b exp=10", {bus.pass, bus.leftover}); end
  endtask

  task automatic test_overflow_timeout();
    bit ok;
    start_run(16'd10);
    for (int i = 0; i < 10; i++) begin
      bus.res_data_0 = 256'(32'h100 + i); bus.res_valid_0 = 1'b1; cyc();
      bus.res_valid_0 = 1'b0; cyc();
    end
    total++; if ({bus.ovf_0, bus.ovf_1, bus.busy} !== 3'b101) begin
      bad++; $display("FAIL ovf_flags got=%b exp=101", {bus.ovf_0, bus.ovf_1, bus.busy}); end
    for (int i = 0; i < 10; i++) begin
      bus.res_data_1 = 256'(32'h100 + i); bus.res_valid_1 = 1'b1; cyc();
      bus.res_valid_1 = 1'b0; cyc();
    end
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_done got=0 exp=1"); end
    cyc();
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL ovf_timeout got=%b exp=1", bus.timeout); end
    total++; if (bus.pass_cnt !== 16'd8) begin bad++; $display("FAIL ovf_pass_cnt got=%0d exp=8", bus.pass_cnt); end
    total++; if (bus.fail_cnt !== 16'd0) begin bad++; $display("FAIL ovf_fail_cnt got=%0d exp=0", bus.fail_cnt); end
    total++; if ({bus.leftover, bus.pass, bus.ovf_0} !== 3'b101) begin
      bad++; $display("FAIL ovf_leftover got=%b exp=101", {bus.leftover, bus.pass, bus.ovf_0}); end
  endtask

  task automatic test_held_valid();
    bit ok;
    start_run(16'd1);
    total++; if ({bus.ovf_0, bus.timeout, bus.leftover, bus.pass_cnt} !== 19'd0) begin
      bad++; $display("FAIL held_clear got=%h exp=0", {bus.ovf_0, bus.timeout, bus.leftover, bus.pass_cnt}); end
    bus.res_data_0 = 256'h55; bus.res_data_1 = 256'h55;
    bus.res_valid_0 = 1'b1; bus.res_valid_1 = 1'b1;
    cyc();
    bus.res_valid_1 = 1'b0;
    cycles(4);
    bus.res_valid_0 = 1'b0;
    cyc();
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL held_done got=0 exp=1"); end
    cyc();
    total++; if (bus.pass_cnt !== 16'd1) begin bad++; $display("FAIL held_pass_cnt got=%0d exp=1", bus.pass_cnt); end
    total++; if ({bus.leftover, bus.pass} !== 2'b01) begin
      bad++; $display("FAIL held_single_capture got=%b exp=01", {bus.leftover, bus.pass}); end
    pulse_both(256'h7, 256'h8);
    pulse_both(256'h9, 256'h9);
    cycles(2);
    total++; if ({bus.pass_cnt, bus.fail_cnt} !== {16'd1, 16'd0}) begin
      bad++; $display("FAIL done_edges_cnt got=%0d/%0d exp=1/0", bus.pass_cnt, bus.fail_cnt); end
    total++; if ({bus.done, bus.pass, bus.leftover} !== 3'b110) begin
      bad++; $display("FAIL done_edges_ignored got=%b exp=110", {bus.done, bus.pass, bus.leftover}); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    start_run(16'd4);
    pulse_both(256'h21, 256'h21);
    pulse_both(256'h22, 256'h22);
    cycles(2);
    total++; if ({bus.busy, bus.pass_cnt} !== {1'b1, 16'd2}) begin
      bad++; $display("FAIL mid_progress got=%b/%0d exp=1/2", bus.busy, bus.pass_cnt); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({bus.busy, bus.done, bus.pass, bus.pass_cnt, bus.fail_cnt, bus.mismatch_valid, bus.ovf_0, bus.ovf_1, bus.timeout, bus.leftover} !== 40'd0) begin
      bad++; $display("FAIL mid_async_reset got=%h exp=0", {bus.busy, bus.done, bus.pass, bus.pass_cnt, bus.fail_cnt, bus.mismatch_valid, bus.ovf_0, bus.ovf_1, bus.timeout, bus.leftover}); end
    cyc();
    rst = 1'b0;
    cyc();
    start_run(16'd1);
    pulse_both(256'h77, 256'h77);
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL post_reset_done got=0 exp=1"); end
    cyc();
    total++; if ({bus.pass, bus.pass_cnt, bus.fail_cnt} !== {1'b1, 16'd1, 16'd0}) begin
      bad++; $display("FAIL post_reset_pass got=%b/%0d/%0d exp=1/1/0", bus.pass, bus.pass_cnt, bus.fail_cnt); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.expected_count = '0;
    bus.res_valid_0 = 1'b0;
    bus.res_valid_1 = 1'b0;
    bus.res_data_0 = '0;
    bus.res_data_1 = '0;
    test_reset();
    test_lagged_pass();
    test_mismatch();
    test_zero_count();
    test_overflow_timeout();
    test_held_valid();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
